// File: rtl/strhw_common_types.sv
// ============================================================================
// Module  : strhw_common_types
// Brief   : Shared types and constants for the strhw message/hash datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package strhw_common_types;

    localparam int BLOCK_BYTES = 64;

    typedef logic [511:0] uint512;
    typedef logic [6:0]   uint7;

    typedef enum logic [1:0] {
        STATE_READY = 2'd0,
        STATE_BUSY  = 2'd1,
        STATE_DONE  = 2'd2,
        STATE_ERROR = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEQ_FILL = 2'd0,
        SEQ_FIRE = 2'd1,
        SEQ_WAIT = 2'd2,
        SEQ_OUT  = 2'd3
    } seq_state_t;

    // A 256-bit digest occupies the low half; the upper half is forced to zero.
    function automatic uint512 mask_digest(input uint512 d, input logic hash_size);
        return hash_size ? {256'b0, d[255:0]} : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/strhw_msg_packer.sv
// ============================================================================
// Module  : strhw_msg_packer
// Brief   : Packs 64-bit message words into a 512-bit block, zeroing invalid
//           bytes and tracking the running byte count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module strhw_msg_packer
    import strhw_common_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_wr,
    input  logic [63:0] i_data,
    input  logic [3:0]  i_bytes,
    input  logic        i_last,
    output uint512      o_block,
    output uint7        o_count,
    output uint7        o_count_next
);

    uint512      r_block;
    uint7        r_count;
    logic [3:0]  w_eff;
    logic [63:0] w_masked;

    // Non-final words always carry a full 8 bytes, whatever s_bytes claims.
    always_comb begin
        w_eff = 4'd8;
        if (i_last && (i_bytes < 4'd8)) begin
            w_eff = i_bytes;
        end
        for (int b = 0; b < 8; b++) begin
            w_masked[8*b +: 8] = (4'(b) < w_eff) ? i_data[8*b +: 8] : 8'h00;
        end
    end

    assign o_count_next = r_count + uint7'(w_eff);
    assign o_block      = r_block;
    assign o_count      = r_count;

    // Word slot is count/8: every word before the final one is exactly 8 bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_block <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_block <= '0;
            r_count <= '0;
        end else if (i_wr) begin
            r_block[{r_count[5:3], 6'b0} +: 64] <= w_masked;
            r_count                             <= o_count_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/strhw_msg_sequencer.sv
// ============================================================================
// Module  : strhw_msg_sequencer
// Brief   : Streams message words into 64-byte blocks, drives the hash core
//           one block at a time and returns the final digest.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module strhw_msg_sequencer
    import strhw_common_types::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [63:0] s_data_i,
    input  logic        s_last_i,
    input  logic [3:0]  s_bytes_i,
    input  logic        hash_size_i,
    output logic        h_valid_o,
    input  logic        h_ready_i,
    output uint512      h_data_o,
    output logic        busy_o,
    output logic        core_trg_o,
    input  state_t      core_state_i,
    output uint512      core_block_o,
    output uint7        core_block_size_o,
    output logic        core_hash_size_o,
    input  uint512      core_hash_i
);

    seq_state_t r_state;
    logic       r_ready;
    logic       r_busy;
    logic       r_trg;
    logic       r_final;
    logic       r_pend_empty;
    logic       r_hash_size;
    logic       r_h_valid;
    uint512     r_h_data;

    uint7       w_count_next;
    logic       w_hs;
    logic       w_full;
    logic       w_core_done;

    assign w_hs        = s_valid_i & r_ready;
    assign w_full      = (w_count_next == uint7'(BLOCK_BYTES));
    assign w_core_done = (r_state == SEQ_WAIT) && (core_state_i == STATE_DONE);

    strhw_msg_packer u_packer (
        .clk          (clk_i),
        .rst          (rst_i),
        .i_clr        (w_core_done),
        .i_wr         (w_hs),
        .i_data       (s_data_i),
        .i_bytes      (s_bytes_i),
        .i_last       (s_last_i),
        .o_block      (core_block_o),
        .o_count      (core_block_size_o),
        .o_count_next (w_count_next)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= SEQ_FILL;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_trg        <= 1'b0;
            r_final      <= 1'b0;
            r_pend_empty <= 1'b0;
            r_hash_size  <= 1'b0;
            r_h_valid    <= 1'b0;
            r_h_data     <= '0;
        end else begin
            r_trg <= 1'b0;
            case (r_state)
                SEQ_FILL: begin
                    r_ready <= 1'b1;
                    if (w_hs) begin
                        if (!r_busy) begin
                            r_hash_size <= hash_size_i;
                        end
                        r_busy <= 1'b1;
                        // Firing straight from the completing handshake keeps trigger latency at one cycle.
                        if (w_full || s_last_i) begin
                            r_ready      <= 1'b0;
                            r_final      <= s_last_i;
                            r_pend_empty <= s_last_i && w_full;
                            r_trg        <= (core_state_i == STATE_READY);
                            r_state      <= SEQ_FIRE;
                        end
                    end
                end
                SEQ_FIRE: begin
                    if (r_trg) begin
                        r_state <= SEQ_WAIT;
                    end else if (core_state_i == STATE_READY) begin
                        r_trg <= 1'b1;
                    end
                end
                SEQ_WAIT: begin
                    if (w_core_done) begin
                        if (!r_final) begin
                            r_ready <= 1'b1;
                            r_state <= SEQ_FILL;
                        end else if (r_pend_empty) begin
                            // Length was a multiple of 64: one more call with an empty block.
                            r_pend_empty <= 1'b0;
                            r_state      <= SEQ_FIRE;
                        end else begin
                            r_h_data  <= mask_digest(core_hash_i, r_hash_size);
                            r_h_valid <= 1'b1;
                            r_state   <= SEQ_OUT;
                        end
                    end
                end
                SEQ_OUT: begin
                    if (h_ready_i) begin
                        r_h_valid <= 1'b0;
                        r_h_data  <= '0;
                        r_busy    <= 1'b0;
                        r_final   <= 1'b0;
                        r_ready   <= 1'b1;
                        r_state   <= SEQ_FILL;
                    end
                end
                default: r_state <= SEQ_FILL;
            endcase
        end
    end

    assign s_ready_o        = r_ready;
    assign busy_o           = r_busy;
    assign core_trg_o       = r_trg;
    assign core_hash_size_o = r_hash_size;
    assign h_valid_o        = r_h_valid;
    assign h_data_o         = r_h_data;

endmodule

`default_nettype wire

// File: doc/strhw_msg_sequencer.md
STRHW_MSG_SEQUENCER -- requirements
Module: strhw_msg_sequencer

Interface
REQ-001 Parameters: none; all widths come from strhw_common_types.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset: clk_i in 1 rising-edge clock; rst_i in 1 asynchronous active-high reset.
REQ-003 s_valid_i in 1 message word valid.
REQ-004 s_ready_o out 1 sequencer accepts word.
REQ-005 s_data_i in 64 message word, byte 0 in bits [7:0].
REQ-006 s_last_i in 1 final word of message.
REQ-007 s_bytes_i in 4 valid bytes in word: 8 when s_last_i=0, 0..8 when s_last_i=1; valid bytes always low-aligned.
REQ-008 hash_size_i in 1 digest size (0=512, 1=256), sampled with first accepted word of a message.
REQ-009 h_valid_o out 1 digest valid.
REQ-010 h_ready_i in 1 digest consumed.
REQ-011 h_data_o out uint512 digest; 256-bit digest in bits [255:0], upper bits zero.
REQ-012 busy_o out 1 message in progress (first word accepted, digest not yet consumed).
REQ-013 core_trg_o out 1 one-cycle start pulse to hash core.
REQ-014 core_state_i in state_t core status.
REQ-015 core_block_o out uint512 block to core; core_block_size_o out uint7 valid bytes 0..64; core_hash_size_o out 1; core_hash_i in uint512 core digest.

Function
REQ-016 FSM states: FILL, FIRE, WAIT, OUT.
REQ-017 FILL: s_ready_o=1; each handshake (s_valid_i & s_ready_o) SHALL write word k into block bits [64k+63:64k] and add s_bytes_i to the byte count; invalid bytes SHALL be stored as zero.
REQ-018 FILL->FIRE on the handshake that makes the count 64 or carries s_last_i=1; s_ready_o SHALL be 0 in every other state.
REQ-019 FIRE: core_trg_o=1 for exactly one cycle, provided core_state_i==STATE_READY; otherwise the FSM holds in FIRE with core_trg_o=0.
REQ-020 core_block_o, core_block_size_o and core_hash_size_o SHALL be held stable from FIRE until WAIT exits.
REQ-021 WAIT exits when core_state_i==STATE_DONE, at the earliest one cycle after the trigger.
REQ-022 WAIT exit, non-final block: clear the block and count, then return to FILL.
REQ-023 Final block with count 64 (message length a multiple of 64 bytes, including a last word that completes the block): set pend_empty; after WAIT, issue an additional FIRE with an all-zero block and size 0.
REQ-024 Final block with count <64: after WAIT, go to OUT.
REQ-025 Empty message (single last word, s_bytes_i=0): exactly one core call with size 0.
REQ-026 OUT: capture core_hash_i (masked to 256 bits if hash_size=1) in h_data_o, assert h_valid_o, and hold until h_ready_i; then clear h_valid_o and busy_o and return to FILL.
REQ-027 Core calls per message SHALL equal floor(L/64)+1, where L is the message length in bytes.
REQ-028 Latency from block-completing handshake to core_trg_o SHALL be 1 cycle when the core is ready.
REQ-029 A protocol violation (s_bytes_i != 8 while s_last_i=0) SHALL be treated as 8 bytes; no error port.

Reset
REQ-030 While rst_i is asserted: FSM=FILL, block, count and pend_empty cleared, s_ready_o=0; after release s_ready_o=1 from the first clock; all other outputs 0 during and after reset.
REQ-031 Reset mid-message SHALL discard all partial state; the next accepted word starts a new message.

Structure
REQ-032 The FSM state enum and the STATE_READY/STATE_DONE members of state_t SHALL reside in strhw_common_types, together with the uint512 and uint7 types and the BLOCK_BYTES=64 constant.
REQ-033 One sub-module, strhw_msg_packer (word-to-512-bit block assembly with byte masking and count), SHALL be used; the sequencer instantiates it alongside the FSM and is placed beside strhw in the hierarchy.

Verification
REQ-034 63-byte message "012345678901234567890123456789012345678901234567890123456789012", hash_size 0 -> one core call, size 63, digest 1b54d01a4af5b9d5cc3d86d68d285462b19abc2475222f35c085122be4ba1ffa00ad30f8767b3a82384c6574f024c311e2a481332b08ef7f41797891c1646f48.
REQ-035 Same message, hash_size 1 -> digest 9d151eefd8590b89daa6ba6cb74af9275dd051026bb149a452fd84e5e57b5500 in [255:0], upper bits 0.
REQ-036 64-byte message -> two core calls (size 64, then size 0 with zero block); digest matches reference model.
REQ-037 Empty message (one last beat, bytes 0) -> one call, size 0; 130-byte message with random s_valid_i gaps -> sizes 64, 64, 2.
REQ-038 h_ready_i held low 20 cycles -> h_valid_o and h_data_o stable and s_ready_o=0 throughout; core held non-ready 10 cycles in FIRE -> no trigger until ready.
REQ-039 rst_i asserted in WAIT -> all outputs 0 immediately, s_ready_o=1 after release; next message digest correct.
